vec_writeback: RTL

Write-back sequencer that sits at the output end of the vector unit. It issues the per-row valid stream into the vector unit, drives the vector unit's `enable` so that pipeline stalls follow downstream back-pressure, and tracks rows through the unit's 2-stage register pipeline. It captures each `vec_out` row into a small FIFO and writes it to the destination SRAM with a valid/ready handshake. In mode 0 (hidden-state update) the destination is the recurrence SRAM; in mode 1 (gated product) it is the intermediate SRAM.

---
 rtl/mmf_pkg.sv | 13 +
 rtl/vec_writeback_fifo.sv | 57 +++++
 rtl/vec_writeback.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mmf_pkg.sv
// Shared types and constants for the vector datapath and its write-back sequencer.
package mmf_pkg;

  localparam int ARR_WIDTH   = 4;
  localparam int FXP_N       = 16;
  localparam int FXP_R       = 8;
  localparam int WB_PIPE_LAT = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wb_state_t;

  typedef logic signed [ARR_WIDTH-1:0][FXP_N-1:0] vec_row_t;

endpackage

// File: rtl/vec_writeback_fifo.sv
// Show-ahead capture FIFO holding vector rows between the vector unit and the SRAM port.
module wb_fifo
  import mmf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  vec_row_t               wdata_i,
  output vec_row_t               rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  vec_row_t               mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W:0]         count_q;
  logic                   do_push;
  logic                   do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once written, and the top gates the head when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vec_writeback.sv
// Write-back sequencer: feeds rows into the vector unit, tracks them through its pipeline,
// buffers results and writes them to the recurrence (mode 0) or intermediate (mode 1) SRAM.
module vec_writeback
  import mmf_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int PIPE_LAT   = WB_PIPE_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              row_valid,
  output logic              row_accept,
  output logic              vu_enable,
  output logic              vu_mode,
  input  vec_row_t          vec_in,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output vec_row_t          wr_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_state_t         state_q;
  logic [ADDR_W-1:0] num_rows_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] rows_in_q,  rows_in_d;
  logic [ADDR_W-1:0] rows_out_q, rows_out_d;
  logic              mode_q;
  logic [PIPE_LAT-1:0] v_q, v_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  vec_row_t          fifo_head;
  logic              push;
  logic              pop;

  // Enable depends only on registered state, so SRAM back-pressure never reaches the vector unit combinationally.
  assign vu_enable  = ((state_q == RUN) || (state_q == DRAIN)) && !fifo_full;
  assign row_accept = row_valid && vu_enable && (rows_in_q < num_rows_q);
  assign push       = v_q[PIPE_LAT-1] && vu_enable;

  assign wr_valid = (fifo_count != '0);
  assign pop      = wr_valid && wr_ready;
  assign wr_data  = fifo_empty ? '0 : fifo_head;
  assign wr_addr  = base_q + rows_out_q;
  assign wr_sel   = mode_q;
  assign vu_mode  = mode_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    v_d        = v_q;
    rows_in_d  = row_accept ? rows_in_q + 1'b1 : rows_in_q;
    rows_out_d = pop ? rows_out_q + 1'b1 : rows_out_q;
    if (vu_enable) begin
      v_d[0] = row_accept;
      for (int i = 1; i < PIPE_LAT; i++) v_d[i] = v_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      num_rows_q <= '0;
      base_q     <= '0;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      mode_q     <= 1'b0;
      v_q        <= '0;
    end else begin
      v_q        <= v_d;
      rows_in_q  <= rows_in_d;
      rows_out_q <= rows_out_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q     <= mode;
            num_rows_q <= num_rows;
            base_q     <= base_addr;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            v_q        <= '0;
            state_q    <= (num_rows == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (rows_in_q == num_rows_q) state_q <= DRAIN;
        end
        DRAIN: begin
          // Look at the post-pop count so done lands the cycle right after the final handshake.
          if (rows_out_d == num_rows_q) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (vec_in),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
